// File: rtl/car_sprite_drawer.sv
// -----------------------------------------------------------------------------
// car_sprite_drawer
//   Keeps the car box on a 160x120 VGA adapter in step with the car location.
//   On a location change it first erases the old box in BG_COLOUR, then draws
//   the new box in CAR_COLOUR, one pixel per clock in raster order. Pixels
//   that fall off the screen are not plotted, but they still take their
//   cycle, so the sequence length does not depend on the position.
//   The first cycle after reset draws the box at the current location.
//   It does not erase anything first.
//
// Ports
//   clk        in   system clock
//   reset_n    in   synchronous, active-low reset
//   ox_loc     in   [7:0] new car top-left x
//   oy_loc     in   [6:0] new car top-left y
//   erase_x    in   [7:0] top-left x of the box to erase
//   erase_y    in   [6:0] top-left y of the box to erase
//   vga_x      out  [7:0] pixel x (registered)
//   vga_y      out  [6:0] pixel y (registered)
//   vga_colour out  [2:0] pixel colour (registered)
//   vga_plot   out  write strobe, one cycle per on-screen pixel
//   busy       out  high while an erase/draw sequence runs
//   done       out  one-cycle pulse after the last draw pixel
//
// Build option
//   CAR_SPRITE_SELF_ERASE_EN : when defined, the erase origin comes from the
//   last fully drawn location, and erase_x/erase_y are ignored.
// -----------------------------------------------------------------------------
module car_sprite_drawer #(
   parameter int         CAR_W           = 16,
   parameter int         CAR_H           = 20,
   parameter logic [2:0] CAR_COLOUR      = 3'b100,
   parameter logic [2:0] BG_COLOUR       = 3'b000,
   parameter int         X_SCREEN_PIXELS = 160,
   parameter int         Y_SCREEN_PIXELS = 120
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] ox_loc,
   input  logic [6:0] oy_loc,
   input  logic [7:0] erase_x,
   input  logic [6:0] erase_y,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

   state_t     r_state;
   logic [7:0] r_drawn_x, r_ex, r_nx;
   logic [6:0] r_drawn_y, r_ey, r_ny;
   logic [4:0] r_cx, r_cy;

   logic [7:0] w_org_x, w_erase_org_x;
   logic [6:0] w_org_y, w_erase_org_y;
   logic [8:0] w_px;
   logic [7:0] w_py;
   logic       w_in_screen, w_last_x, w_last_y, w_moved, w_erasing;

`ifdef CAR_SPRITE_SELF_ERASE_EN
   // Erase whatever this block last put on screen.
   assign w_erase_org_x = r_drawn_x;
   assign w_erase_org_y = r_drawn_y;
   logic  w_unused_erase;
   assign w_unused_erase = ^{erase_x, erase_y};
`else
   assign w_erase_org_x = erase_x;
   assign w_erase_org_y = erase_y;
`endif

   assign w_erasing = (r_state == S_ERASE);
   assign w_org_x   = w_erasing ? r_ex : r_nx;
   assign w_org_y   = w_erasing ? r_ey : r_ny;

   // One bit wider than the screen coordinates, so a box that hangs off the
   // right or bottom edge is clipped and does not wrap to x/y = 0.
   assign w_px        = {1'b0, w_org_x} + {4'b0, r_cx};
   assign w_py        = {1'b0, w_org_y} + {3'b0, r_cy};
   assign w_in_screen = (w_px < 9'(X_SCREEN_PIXELS)) && (w_py < 8'(Y_SCREEN_PIXELS));
   assign w_last_x    = (r_cx == 5'(CAR_W - 1));
   assign w_last_y    = (r_cy == 5'(CAR_H - 1));
   assign w_moved     = ({ox_loc, oy_loc} != {r_drawn_x, r_drawn_y});

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= S_INIT;
         r_drawn_x  <= '0;
         r_drawn_y  <= '0;
         r_ex       <= '0;
         r_ey       <= '0;
         r_nx       <= '0;
         r_ny       <= '0;
         r_cx       <= '0;
         r_cy       <= '0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         vga_plot <= 1'b0;
         done     <= 1'b0;
         case (r_state)
            S_INIT: begin
               r_nx    <= ox_loc;
               r_ny    <= oy_loc;
               r_cx    <= '0;
               r_cy    <= '0;
               busy    <= 1'b1;
               r_state <= S_DRAW;
            end
            S_IDLE: begin
               busy <= 1'b0;
               if (w_moved) begin
                  r_nx    <= ox_loc;
                  r_ny    <= oy_loc;
                  r_ex    <= w_erase_org_x;
                  r_ey    <= w_erase_org_y;
                  r_cx    <= '0;
                  r_cy    <= '0;
                  busy    <= 1'b1;
                  r_state <= S_ERASE;
               end
            end
            S_ERASE, S_DRAW: begin
               vga_x      <= w_px[7:0];
               vga_y      <= w_py[6:0];
               vga_colour <= w_erasing ? BG_COLOUR : CAR_COLOUR;
               vga_plot   <= w_in_screen;
               if (w_last_x) begin
                  r_cx <= '0;
                  if (w_last_y) begin
                     r_cy    <= '0;
                     r_state <= w_erasing ? S_DRAW : S_DONE;
                  end else begin
                     r_cy <= r_cy + 5'd1;
                  end
               end else begin
                  r_cx <= r_cx + 5'd1;
               end
            end
            S_DONE: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               r_drawn_x <= r_nx;
               r_drawn_y <= r_ny;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_car_sprite_drawer.sv
// -----------------------------------------------------------------------------
// tb_car_sprite_drawer
//   Scoreboard bench for car_sprite_drawer at default parameters. Each move
//   pushes its expected pixel stream (erase box, then draw box, with
//   off-screen pixels dropped) onto a queue. A negedge monitor pops one entry
//   per vga_plot and compares it. The sequencer checks done latency, the busy
//   length, reset behaviour and that the queue drains.
//   The bench follows CAR_SPRITE_SELF_ERASE_EN for the erase origin.
// -----------------------------------------------------------------------------
module tb_car_sprite_drawer;

   localparam int W = 16;
   localparam int H = 20;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] ox_loc, erase_x;
   logic [6:0] oy_loc, erase_y;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot, busy, done;

   int n_cmp = 0;
   int n_err = 0;
   int n_pop = 0;
   logic [17:0] exp_q[$];
   logic [7:0]  m_drawn_x = 8'd0;
   logic [6:0]  m_drawn_y = 7'd0;

   car_sprite_drawer dut (
      .clk(clk), .reset_n(reset_n),
      .ox_loc(ox_loc), .oy_loc(oy_loc), .erase_x(erase_x), .erase_y(erase_y),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .vga_plot(vga_plot), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected raster of one box. Off-screen pixels produce no plot.
   task automatic push_box(input int x0, input int y0, input logic [2:0] col);
      for (int cy = 0; cy < H; cy++)
         for (int cx = 0; cx < W; cx++)
            if (x0 + cx < 160 && y0 + cy < 120)
               exp_q.push_back({8'(x0 + cx), 7'(y0 + cy), col});
   endtask

   // Expected erase origin for a move, given the inputs at the trigger.
   task automatic push_move(input int ex, input int ey, input int nx, input int ny);
`ifdef CAR_SPRITE_SELF_ERASE_EN
      push_box(m_drawn_x, m_drawn_y, 3'b000);
`else
      push_box(ex, ey, 3'b000);
`endif
      push_box(nx, ny, 3'b100);
      m_drawn_x = 8'(nx);
      m_drawn_y = 7'(ny);
   endtask

   always @(negedge clk) begin
      if (vga_plot === 1'b1) begin
         if (exp_q.size() == 0) chk("extra_plot", {vga_x, vga_y, vga_colour}, 32'h0);
         else begin
            chk("pixel", {vga_x, vga_y, vga_colour}, exp_q.pop_front());
            n_pop++;
         end
      end
   end

   // Counts negedges until done shows up (first negedge = n 1).
   task automatic wait_done(input int bound, inout int n, inout int nbusy);
      while (n < bound) begin
         @(negedge clk);
         n++;
         if (busy === 1'b1) nbusy++;
         if (done === 1'b1) return;
      end
      chk("done_timeout", n, 0);
   endtask

   task automatic run_move(input string tag, input int ex, input int ey,
                           input int nx, input int ny);
      int n, nb;
      n = 0; nb = 0;
      push_move(ex, ey, nx, ny);
      erase_x = 8'(ex); erase_y = 7'(ey); ox_loc = 8'(nx); oy_loc = 7'(ny);
      wait_done(2000, n, nb);
      chk({tag, "_latency"}, n, 642);
      chk({tag, "_busy"}, nb, 641);
      chk({tag, "_qempty"}, exp_q.size(), 0);
   endtask

   initial begin
      int n, nb, p0;
      reset_n = 1'b0; ox_loc = 8'd70; oy_loc = 7'd85; erase_x = 8'd0; erase_y = 7'd0;
      repeat (3) @(negedge clk);
      chk("rst_plot", vga_plot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_xyc", {vga_x, vga_y, vga_colour}, 0);

      // INIT draw only, no erase
      push_box(70, 85, 3'b100);
      m_drawn_x = 8'd70; m_drawn_y = 7'd85;
      reset_n = 1'b1;
      n = 0; nb = 0;
      wait_done(2000, n, nb);
      chk("init_latency", n, 322);
      chk("init_busy", nb, 321);
      chk("init_qempty", exp_q.size(), 0);
      @(negedge clk);
      chk("done_pulse", done, 0);

      run_move("move", 70, 85, 30, 85);
      run_move("clip", 30, 85, 150, 110);

      // Change during the sequence: first completes, second follows at once
      push_move(150, 110, 70, 85);
      erase_x = 8'd150; erase_y = 7'd110; ox_loc = 8'd70; oy_loc = 7'd85;
      n = 0; nb = 0;
      repeat (100) begin @(negedge clk); n++; if (busy === 1'b1) nb++; end
      push_move(70, 85, 110, 85);
      erase_x = 8'd70; erase_y = 7'd85; ox_loc = 8'd110;
      wait_done(2000, n, nb);
      chk("busy_chg_latency", n, 642);
      n = 0; nb = 0;
      wait_done(2000, n, nb);
      chk("second_latency", n, 642);
      chk("second_busy", nb, 641);
      chk("second_qempty", exp_q.size(), 0);

      // Reset in the middle of ERASE
      @(negedge clk);
      push_box(110, 85, 3'b000);
      p0 = n_pop;
      erase_x = 8'd110; erase_y = 7'd85; ox_loc = 8'd30;
      repeat (200) @(negedge clk);
      reset_n = 1'b0; ox_loc = 8'd20; oy_loc = 7'd30;
      @(negedge clk);
      chk("abort_plot", vga_plot, 0);
      chk("abort_busy", busy, 0);
      chk("abort_npix", n_pop - p0, 199);
      exp_q.delete();
      push_box(20, 30, 3'b100);
      m_drawn_x = 8'd20; m_drawn_y = 7'd30;
      reset_n = 1'b1;
      n = 0; nb = 0;
      wait_done(2000, n, nb);
      chk("reinit_latency", n, 322);
      chk("reinit_qempty", exp_q.size(), 0);

      // Same location again: nothing happens
      erase_x = 8'd99; erase_y = 7'd9;
      nb = 0;
      repeat (20) begin @(negedge clk); if (busy === 1'b1) nb++; end
      chk("noredraw_busy", nb, 0);

      // Erase inputs parked at (0,0); erase origin depends on the build
      run_move("selferase", 0, 0, 110, 85);

      repeat (3) @(negedge clk);
      chk("final_qempty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/car_sprite_drawer.md
Name: car_sprite_drawer

Overview:
- Downstream of the car-movement controller. Consumes the car's current location (ox_loc/oy_loc) and erase location (erase_x/erase_y), and streams pixel writes to the 160x120 VGA adapter.
- Keeps the on-screen car consistent: on every location change it erases the old box in the background colour, then draws the new box in the car colour, one pixel per clock.

Parameters:
- CAR_W, 16, car box width in pixels (1..32)
- CAR_H, 20, car box height in pixels (1..32)
- CAR_COLOUR, 3'b100, 3-bit colour used for draw
- BG_COLOUR, 3'b000, 3-bit colour used for erase
- X_SCREEN_PIXELS, 160, screen width; pixels with x >= this are clipped
- Y_SCREEN_PIXELS, 120, screen height; pixels with y >= this are clipped

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- ox_loc  in  8  car top-left x (new position)
- oy_loc  in  7  car top-left y (new position)
- erase_x  in  8  top-left x of box to erase
- erase_y  in  7  top-left y of box to erase
- vga_x  out  8  pixel x to adapter
- vga_y  out  7  pixel y to adapter
- vga_colour  out  3  pixel colour to adapter
- vga_plot  out  1  write strobe; adapter writes the pixel when high
- busy  out  1  high while an erase/draw sequence runs
- done  out  1  one-cycle pulse after the last draw pixel

Behaviour:
- Reset is synchronous, active-low, and dominates everything. At reset: state=INIT, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0, pixel counters=0, drawn_x/drawn_y=0. Reset mid-sequence aborts immediately: no further plots; the partial box is left on screen.
- Internal registers:
  - drawn_x/drawn_y: location last fully drawn.
  - ex/ey: latched erase origin.
  - nx/ny: latched draw origin.
  - cx (5b), cy (5b): pixel offset counters.
- States:
  - INIT: first cycle after reset. Latch nx/ny <= ox_loc/oy_loc; busy <= 1; go to DRAW. No erase happens.
  - IDLE: busy=0. If {ox_loc,oy_loc} != {drawn_x,drawn_y}, then latch nx/ny <= ox_loc/oy_loc and ex/ey <= erase_x/erase_y, busy <= 1, cx=cy=0, go to ERASE. Otherwise stay in IDLE.
  - ERASE: each cycle present pixel (ex+cx, ey+cy) with BG_COLOUR. cx increments; on cx==CAR_W-1, cx<=0 and cy increments. After pixel (CAR_W-1, CAR_H-1): cx=cy=0, go to DRAW. Duration is exactly CAR_W*CAR_H cycles.
  - DRAW: same raster order at (nx+cx, ny+cy) with CAR_COLOUR; same duration. After the last pixel, go to DONE.
  - DONE: one cycle. done=1, busy=0, vga_plot=0, drawn_x/drawn_y <= nx/ny. Next state is IDLE.
- Output timing: vga_x/vga_y/vga_colour/vga_plot are registered. The first plot appears the cycle after entering ERASE or DRAW. vga_plot is high for exactly one cycle per in-screen pixel.
- Latency: from location change seen in IDLE to done is 2*CAR_W*CAR_H + 2 cycles, or 642 at defaults. From INIT to done is CAR_W*CAR_H + 2 cycles.
- Arithmetic: coordinate sums are 9-bit (x) and 8-bit (y) internally. A pixel whose sum is >= X_SCREEN_PIXELS or >= Y_SCREEN_PIXELS is clipped: vga_plot=0 that cycle, counters still advance, and sequence duration is unchanged. vga_x/vga_y carry the truncated low bits on clipped cycles (don't-care).
- Inputs changing while busy are ignored. Comparison resumes in IDLE, so a change during a sequence triggers a new sequence right after DONE.
- If the new location equals drawn_x/drawn_y when IDLE is re-entered, nothing happens (no redundant redraw).
- Inputs that are X/unknown are not sampled outside INIT and the IDLE trigger cycle.

Optional Feature:
- Macro: CAR_SPRITE_SELF_ERASE_EN.
- When defined: erase_x/erase_y are ignored, and the IDLE trigger latches ex/ey <= drawn_x/drawn_y. The box actually on screen is always erased, independent of upstream erase outputs.
- When undefined: erase origin comes from the erase_x/erase_y inputs, as described above.
- Ports are identical in both builds.

Test Plan:
- Reset with ox=70, oy=85, then release -> 320 plots at x 70..85, y 85..104, colour 3'b100, raster order. done pulses at cycle 322; no BG_COLOUR plots occur.
- From drawn (70,85), set ox=30 and erase=(70,85) -> 320 plots colour 000 over x 70..85, y 85..104, then 320 plots colour 100 over x 30..45. done after 642 cycles; busy high for 641 cycles.
- ox=150, oy=110 -> only x 150..159, y 110..119 are plotted (100 plots per phase). Sequence still lasts 642 cycles.
- Change ox 70->110 at cycle 100 of a running sequence -> current sequence completes unchanged. The second sequence starts the cycle after done, with erase from the latched erase inputs.
- Assert reset_n=0 at cycle 200 of ERASE -> next cycle vga_plot=0, busy=0. After release, INIT redraw at the current ox/oy.
- With CAR_SPRITE_SELF_ERASE_EN defined and erase inputs held at (0,0): move from (70,85) to (110,85) -> erase plots at x 70..85, not at 0..15.
